// File: rtl/system86_video_pkg.sv
// Default System86 video timing constants and shared types for the
// timing generator and anything that needs to know the raster geometry.
package system86_video_pkg;

  // Raster counters are 9 bits; every total must fit in 512.
  localparam int CNT_W = 9;

  // 49.152 MHz master clock divided down to a 6.144 MHz pixel clock.
  localparam int MASTER_HZ   = 49_152_000;
  localparam int PIX_CLK_DIV = 8;
  localparam int PIX_HZ      = MASTER_HZ / PIX_CLK_DIV;

  // Horizontal geometry, in pixels.
  localparam int H_TOTAL_DEF      = 384;
  localparam int H_ACTIVE_DEF     = 288;
  localparam int H_SYNC_START_DEF = 300;
  localparam int H_SYNC_LEN_DEF   = 32;

  // Vertical geometry, in lines.
  localparam int V_TOTAL_DEF      = 264;
  localparam int V_ACTIVE_DEF     = 224;
  localparam int V_SYNC_START_DEF = 240;
  localparam int V_SYNC_LEN_DEF   = 8;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // True when c lies in the half-open window [start, start+len).
  function automatic logic in_window(cnt_t c, int start, int len);
    return (int'(c) >= start) && (int'(c) < start + len);
  endfunction

endpackage

// File: rtl/system86_pix_ce_gen.sv
// Master-clock divider producing the one-clk-wide pixel clock enable.
module system86_pix_ce_gen #(
  parameter int CLK_DIV = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_pix_ce
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div;

  // Free-running divider; reset restarts the phase so the first enable
  // lands CLK_DIV-1 clks after release.
  always_ff @(posedge i_clk) begin
    if (!i_rst || r_div == DIV_LAST) r_div <= '0;
    else                             r_div <= r_div + 1'b1;
  end

  // Qualified with rst so that CLK_DIV=1 (div stuck at its last value)
  // still reports no enable while reset is held.
  assign o_pix_ce = i_rst & (r_div == DIV_LAST);

endmodule

// File: rtl/system86_video_timing.sv
// Raster counters, blanking/sync decode and registered RGB/sync output
// stage for the System86 video path.
module system86_video_timing
  import system86_video_pkg::*;
#(
  parameter int CLK_DIV      = PIX_CLK_DIV,
  parameter int H_TOTAL      = H_TOTAL_DEF,
  parameter int H_ACTIVE     = H_ACTIVE_DEF,
  parameter int H_SYNC_START = H_SYNC_START_DEF,
  parameter int H_SYNC_LEN   = H_SYNC_LEN_DEF,
  parameter int V_TOTAL      = V_TOTAL_DEF,
  parameter int V_ACTIVE     = V_ACTIVE_DEF,
  parameter int V_SYNC_START = V_SYNC_START_DEF,
  parameter int V_SYNC_LEN   = V_SYNC_LEN_DEF,
  parameter int SYNC_POL     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       R_in,
  input  logic [7:0]       G_in,
  input  logic [7:0]       B_in,
  output logic             pix_ce,
  output logic [CNT_W-1:0] hcnt,
  output logic [CNT_W-1:0] vcnt,
  output logic             hblank,
  output logic             vblank,
  output logic             de,
  output logic             frame_start,
  output logic [7:0]       R,
  output logic [7:0]       G,
  output logic [7:0]       B,
  output logic             HSYNC,
  output logic             VSYNC
);

  localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);
  localparam logic POL    = (SYNC_POL != 0);

  logic w_pix_ce;
  logic w_h_wrap;
  logic w_v_wrap;
  logic w_hs_act;
  logic w_vs_act;
  logic w_hblank;
  logic w_vblank;
  logic w_de;
  cnt_t r_hcnt;
  cnt_t r_vcnt;
  rgb_t r_rgb;
  logic r_hsync;
  logic r_vsync;

  system86_pix_ce_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_ce (
    .i_clk    (clk),
    .i_rst    (rst),
    .o_pix_ce (w_pix_ce)
  );

  assign w_h_wrap = (r_hcnt == H_LAST);
  assign w_v_wrap = (r_vcnt == V_LAST);

  // Blanking and sync windows decode straight from the registered counters.
  // vcnt only moves on a line wrap, so vs_act only changes at line boundaries.
  assign w_hblank = int'(r_hcnt) >= H_ACTIVE;
  assign w_vblank = int'(r_vcnt) >= V_ACTIVE;
  assign w_de     = !w_hblank && !w_vblank;
  assign w_hs_act = in_window(r_hcnt, H_SYNC_START, H_SYNC_LEN);
  assign w_vs_act = in_window(r_vcnt, V_SYNC_START, V_SYNC_LEN);

  // Pixel/line counters, stepping once per pixel enable.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (w_pix_ce) begin
      r_hcnt <= w_h_wrap ? '0 : r_hcnt + 1'b1;
      if (w_h_wrap) r_vcnt <= w_v_wrap ? '0 : r_vcnt + 1'b1;
    end
  end

  // Output stage: colour and sync share one register stage so the pins
  // stay aligned, one pixel behind the counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rgb   <= '0;
      r_hsync <= !POL;
      r_vsync <= !POL;
    end else if (w_pix_ce) begin
      r_rgb   <= w_de ? rgb_t'{R_in, G_in, B_in} : '0;
      r_hsync <= w_hs_act ~^ POL;
      r_vsync <= w_vs_act ~^ POL;
    end
  end

  assign pix_ce      = w_pix_ce;
  assign hcnt        = r_hcnt;
  assign vcnt        = r_vcnt;
  assign hblank      = w_hblank;
  assign vblank      = w_vblank;
  assign de          = w_de;
  assign frame_start = w_pix_ce & w_h_wrap & w_v_wrap;
  assign R           = r_rgb.r;
  assign G           = r_rgb.g;
  assign B           = r_rgb.b;
  assign HSYNC       = r_hsync;
  assign VSYNC       = r_vsync;

endmodule

// File: tb/tb_system86_video_timing.sv
// Bench for system86_video_timing on a shrunken raster so whole frames
// fit in a short run; a second instance covers the CLK_DIV=1 corner.
`timescale 1ns/1ps
module tb_system86_video_timing;
  import system86_video_pkg::*;

  localparam int CD = 4, HT = 24, HA = 16, HSS = 18, HSL = 3;
  localparam int VT = 12, VA = 8, VSS = 9, VSL = 2;
  localparam int FRAME = HT * VT * CD;

  typedef struct { logic [7:0] r, g, b; logic hs, vs; } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] R_in = 8'h00, G_in = 8'h00, B_in = 8'h00;

  logic pix_ce, hblank, vblank, de, frame_start, HSYNC, VSYNC;
  logic [CNT_W-1:0] hcnt, vcnt;
  logic [7:0] R, G, B;

  logic u1_pix_ce, u1_hblank, u1_vblank, u1_de, u1_fs, u1_hs, u1_vs;
  logic [CNT_W-1:0] u1_hcnt, u1_vcnt;
  logic [7:0] u1_r, u1_g, u1_b;

  int n_checks = 0, n_errors = 0;
  int m_div = 0, m_h = 0, m_v = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  system86_video_timing #(
    .CLK_DIV(CD), .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_LEN(HSL),
    .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_LEN(VSL), .SYNC_POL(0)
  ) dut (
    .clk(clk), .rst(rst), .R_in(R_in), .G_in(G_in), .B_in(B_in),
    .pix_ce(pix_ce), .hcnt(hcnt), .vcnt(vcnt), .hblank(hblank), .vblank(vblank),
    .de(de), .frame_start(frame_start), .R(R), .G(G), .B(B),
    .HSYNC(HSYNC), .VSYNC(VSYNC)
  );

  system86_video_timing #(
    .CLK_DIV(1), .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_LEN(HSL),
    .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_LEN(VSL), .SYNC_POL(0)
  ) dut1 (
    .clk(clk), .rst(rst), .R_in(R_in), .G_in(G_in), .B_in(B_in),
    .pix_ce(u1_pix_ce), .hcnt(u1_hcnt), .vcnt(u1_vcnt), .hblank(u1_hblank),
    .vblank(u1_vblank), .de(u1_de), .frame_start(u1_fs), .R(u1_r), .G(u1_g),
    .B(u1_b), .HSYNC(u1_hs), .VSYNC(u1_vs)
  );

  // Reference raster for one clk edge: queue the pin values the edge must
  // produce, then advance the model and sample #1 after the edge.
  task automatic step();
    exp_t e;
    if (!rst) begin
      m_div = 0; m_h = 0; m_v = 0;
      sb.delete();
    end else if (m_div == CD - 1) begin
      e.r  = (m_h < HA && m_v < VA) ? R_in : 8'h00;
      e.g  = (m_h < HA && m_v < VA) ? G_in : 8'h00;
      e.b  = (m_h < HA && m_v < VA) ? B_in : 8'h00;
      e.hs = !(m_h >= HSS && m_h < HSS + HSL);
      e.vs = !(m_v >= VSS && m_v < VSS + VSL);
      sb.push_back(e);
      m_div = 0;
      m_h++;
      if (m_h == HT) begin
        m_h = 0;
        m_v++;
        if (m_v == VT) m_v = 0;
      end
    end else begin
      m_div++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; R_in = 8'hFF; G_in = 8'hFF; B_in = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if ({R, G, B, HSYNC, VSYNC, pix_ce, frame_start} !== {24'h0, 1'b1, 1'b1, 1'b0, 1'b0} ||
          hcnt !== '0 || vcnt !== '0) begin
        n_errors++;
        $display("FAIL reset_out[%0d]: got R=%h G=%h B=%h HS=%b VS=%b ce=%b fs=%b h=%0d v=%0d, want 0 0 0 1 1 0 0 h=0 v=0",
                 i, R, G, B, HSYNC, VSYNC, pix_ce, frame_start, hcnt, vcnt);
      end
      n_checks++;
      if ({hblank, vblank, de} !== 3'b001 || u1_pix_ce !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_flags[%0d]: got hb/vb/de=%b%b%b ce1=%b, want 001 ce1=0",
                 i, hblank, vblank, de, u1_pix_ce);
      end
    end
  endtask

  task automatic test_divider();
    int ones = 0;
    rst = 1'b1; R_in = 8'h11; G_in = 8'h22; B_in = 8'h33;
    #1;
    for (int k = 0; k < 1000; k++) begin
      n_checks++;
      if (pix_ce !== ((k % CD) == CD - 1)) begin
        n_errors++;
        $display("FAIL div_phase clk %0d: pix_ce=%b, want %b", k, pix_ce, (k % CD) == CD - 1);
      end
      if (pix_ce === 1'b1) ones++;
      n_checks++;
      if (u1_pix_ce !== 1'b1 || u1_hcnt !== CNT_W'(k % HT)) begin
        n_errors++;
        $display("FAIL div1 clk %0d: ce=%b hcnt=%0d, want ce=1 hcnt=%0d", k, u1_pix_ce, u1_hcnt, k % HT);
      end
      step();
    end
    n_checks++;
    if (ones != 1000 / CD) begin
      n_errors++;
      $display("FAIL div_count: %0d enables in 1000 clks, want %0d", ones, 1000 / CD);
    end
    sb.delete();
  endtask

  task automatic test_line();
    int fall_h = -1, low_clks = 0, n_falls = 0, max_h = 0, prev_h;
    logic prev_hs;
    exp_t e;
    for (int k = 0; k < 2 * HT * CD; k++) begin
      prev_h = int'(hcnt); prev_hs = HSYNC;
      R_in = 8'($urandom); G_in = 8'($urandom); B_in = 8'($urandom);
      step();
      n_checks++;
      if (hcnt !== CNT_W'(m_h) || vcnt !== CNT_W'(m_v) || hblank !== (m_h >= HA) ||
          de !== (m_h < HA && m_v < VA)) begin
        n_errors++;
        $display("FAIL line_cnt: h=%0d v=%0d hb=%b de=%b, want h=%0d v=%0d hb=%b de=%b",
                 hcnt, vcnt, hblank, de, m_h, m_v, m_h >= HA, m_h < HA && m_v < VA);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if ({R, G, B, HSYNC, VSYNC} !== {e.r, e.g, e.b, e.hs, e.vs}) begin
          n_errors++;
          $display("FAIL line_pix: got %h%h%h hs=%b vs=%b, want %h%h%h hs=%b vs=%b",
                   R, G, B, HSYNC, VSYNC, e.r, e.g, e.b, e.hs, e.vs);
        end
      end
      if (prev_hs === 1'b1 && HSYNC === 1'b0) begin
        n_falls++; fall_h = int'(hcnt); low_clks = 0;
      end
      if (HSYNC === 1'b0) low_clks++;
      if (prev_hs === 1'b0 && HSYNC === 1'b1 && n_falls > 0) begin
        n_checks++;
        if (low_clks != HSL * CD) begin
          n_errors++;
          $display("FAIL hsync_width: low for %0d clks, want %0d", low_clks, HSL * CD);
        end
      end
      if (int'(hcnt) > max_h) max_h = int'(hcnt);
      if (prev_h == HT - 1 && int'(hcnt) != prev_h) begin
        n_checks++;
        if (hcnt !== '0) begin
          n_errors++;
          $display("FAIL h_wrap: hcnt after %0d is %0d, want 0", HT - 1, hcnt);
        end
      end
    end
    n_checks++;
    if (n_falls < 1 || fall_h != HSS + 1) begin
      n_errors++;
      $display("FAIL hsync_start: %0d falls, hcnt at fall %0d, want hcnt %0d", n_falls, fall_h, HSS + 1);
    end
    n_checks++;
    if (max_h != HT - 1) begin
      n_errors++;
      $display("FAIL h_max: max hcnt %0d, want %0d", max_h, HT - 1);
    end
  endtask

  task automatic test_frame();
    int fs_cnt = 0, vwraps = 0, nvf = 0, vlow = 0, vf_h = -1, vf_v = -1, prev_v;
    logic prev_vs;
    exp_t e;
    for (int k = 0; k < 2 * FRAME; k++) begin
      prev_v = int'(vcnt); prev_vs = VSYNC;
      step();
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if ({R, G, B, HSYNC, VSYNC} !== {e.r, e.g, e.b, e.hs, e.vs}) begin
          n_errors++;
          $display("FAIL frame_pix: got %h%h%h hs=%b vs=%b, want %h%h%h hs=%b vs=%b",
                   R, G, B, HSYNC, VSYNC, e.r, e.g, e.b, e.hs, e.vs);
        end
      end
      if (frame_start === 1'b1) begin
        fs_cnt++;
        n_checks++;
        if (hcnt !== CNT_W'(HT - 1) || vcnt !== CNT_W'(VT - 1) || pix_ce !== 1'b1) begin
          n_errors++;
          $display("FAIL fs_pos: frame_start at h=%0d v=%0d ce=%b, want h=%0d v=%0d ce=1",
                   hcnt, vcnt, pix_ce, HT - 1, VT - 1);
        end
      end
      if (prev_v == VT - 1 && vcnt !== CNT_W'(VT - 1)) begin
        vwraps++;
        n_checks++;
        if (vcnt !== '0 || hcnt !== '0) begin
          n_errors++;
          $display("FAIL v_wrap: after v=%0d got h=%0d v=%0d, want 0 0", VT - 1, hcnt, vcnt);
        end
      end
      if (prev_vs === 1'b1 && VSYNC === 1'b0) begin
        nvf++; vf_h = int'(hcnt); vf_v = int'(vcnt); vlow = 0;
      end
      if (VSYNC === 1'b0) vlow++;
      if (prev_vs === 1'b0 && VSYNC === 1'b1 && nvf > 0) begin
        n_checks++;
        if (vlow != VSL * HT * CD) begin
          n_errors++;
          $display("FAIL vsync_width: low for %0d clks, want %0d", vlow, VSL * HT * CD);
        end
      end
    end
    n_checks++;
    if (fs_cnt != 2) begin
      n_errors++;
      $display("FAIL fs_count: %0d pulses in %0d clks, want 2", fs_cnt, 2 * FRAME);
    end
    n_checks++;
    if (vwraps != 2) begin
      n_errors++;
      $display("FAIL v_wraps: %0d wraps, want 2", vwraps);
    end
    n_checks++;
    if (nvf < 1 || vf_h != 1 || vf_v != VSS) begin
      n_errors++;
      $display("FAIL vsync_start: falls=%0d at h=%0d v=%0d, want h=1 v=%0d", nvf, vf_h, vf_v, VSS);
    end
  endtask

  task automatic test_gate();
    int ph, pv, hits = 0;
    logic pce;
    exp_t e;
    R_in = 8'hA5; G_in = 8'h5A; B_in = 8'h3C;
    for (int k = 0; k < FRAME + CD; k++) begin
      ph = int'(hcnt); pv = int'(vcnt); pce = pix_ce;
      step();
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if ({R, G, B} !== {e.r, e.g, e.b}) begin
          n_errors++;
          $display("FAIL gate_pix: got %h%h%h, want %h%h%h", R, G, B, e.r, e.g, e.b);
        end
      end
      if (pce === 1'b1) begin
        if (ph == HA - 1 && pv == 0) begin
          hits++; n_checks++;
          if (R !== 8'hA5) begin
            n_errors++; $display("FAIL gate_last_active: R=%h, want a5", R);
          end
        end
        if (ph == HA && pv == 0) begin
          hits++; n_checks++;
          if (R !== 8'h00) begin
            n_errors++; $display("FAIL gate_first_hblank: R=%h, want 00", R);
          end
        end
        if (ph == 0 && pv == VA) begin
          hits++; n_checks++;
          if ({R, G, B} !== 24'h0) begin
            n_errors++; $display("FAIL gate_vblank: RGB=%h%h%h, want 000000", R, G, B);
          end
        end
        if (ph == 0 && pv == 0) begin
          hits++; n_checks++;
          if ({R, G, B} !== 24'hA55A3C) begin
            n_errors++; $display("FAIL gate_origin: RGB=%h%h%h, want a55a3c", R, G, B);
          end
        end
      end
    end
    n_checks++;
    if (hits != 4) begin
      n_errors++;
      $display("FAIL gate_coverage: %0d target pixels seen, want 4", hits);
    end
  endtask

  task automatic test_midreset();
    int j = 0, n = 0;
    bit found = 0;
    R_in = 8'hC3; G_in = 8'h3C; B_in = 8'h99;
    while (!found && n < 2 * FRAME) begin
      if (hcnt === CNT_W'(10) && vcnt === CNT_W'(5) && pix_ce === 1'b1) found = 1;
      else begin step(); n++; end
    end
    n_checks++;
    if (!found || R !== 8'hC3) begin
      n_errors++;
      $display("FAIL midrst_setup: found=%0d R=%h, want found=1 R=c3", found, R);
    end
    rst = 1'b0;
    step();
    n_checks++;
    if ({R, G, B, HSYNC, VSYNC, pix_ce, frame_start} !== {24'h0, 1'b1, 1'b1, 1'b0, 1'b0} ||
        hcnt !== '0 || vcnt !== '0) begin
      n_errors++;
      $display("FAIL midrst_state: R=%h G=%h B=%h HS=%b VS=%b ce=%b fs=%b h=%0d v=%0d, want reset values",
               R, G, B, HSYNC, VSYNC, pix_ce, frame_start, hcnt, vcnt);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (u1_pix_ce !== 1'b1) begin
      n_errors++;
      $display("FAIL midrst_ce1: pix_ce=%b at clk 0, want 1", u1_pix_ce);
    end
    while (pix_ce !== 1'b1 && j < 4 * CD) begin
      step(); j++;
    end
    n_checks++;
    if (j != CD - 1 || hcnt !== '0) begin
      n_errors++;
      $display("FAIL midrst_phase: first pix_ce at clk %0d hcnt=%0d, want clk %0d hcnt=0", j, hcnt, CD - 1);
    end
  endtask

  initial begin
    test_reset();
    test_divider();
    test_line();
    test_frame();
    test_gate();
    test_midreset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/system86_video_timing.md
# system86_video_timing

Video timing generator and output stage for the System86 board model. It divides the master clock down to the 6.144 MHz pixel rate and produces the raster counters, blanking and sync. It gates the RGB supplied by the pixel pipeline and drives the board-level R/G/B/HSYNC/VSYNC pins, which the simulation bench samples and logs.

## Interface
Parameters:
- CLK_DIV, 8, master clocks per pixel (49.152 MHz / 8); legal range ≥1
- H_TOTAL, 384, pixels per line
- H_ACTIVE, 288, visible pixels per line
- H_SYNC_START, 300, first hcnt value with hsync active
- H_SYNC_LEN, 32, hsync width in pixels
- V_TOTAL, 264, lines per frame
- V_ACTIVE, 224, visible lines
- V_SYNC_START, 240, first vcnt value with vsync active
- V_SYNC_LEN, 8, vsync width in lines
- SYNC_POL, 0, 0 = sync pins active-low, 1 = active-high

Ports:
- clk  in  1  master clock
- rst  in  1  reset; synchronous, active-low
- R_in, G_in, B_in  in  8 each  pixel colour for the current (hcnt, vcnt)
- pix_ce  out  1  pixel clock enable, one clk wide
- hcnt  out  9  horizontal position, 0..H_TOTAL-1
- vcnt  out  9  vertical position, 0..V_TOTAL-1
- hblank, vblank, de  out  1  blanking flags and display enable, aligned with the counters
- frame_start  out  1  one-clk pulse when the counters move to (0,0)
- R, G, B  out  8 each  gated pixel output
- HSYNC, VSYNC  out  1  sync pins, polarity set by SYNC_POL

## Operation
- Divider: div counts 0..CLK_DIV-1 every clk and wraps. pix_ce = (div == CLK_DIV-1), decoded from the registered div. With CLK_DIV=1, pix_ce is 1 on every clk while rst is high.
- Counters advance only on pix_ce:
  - hcnt wraps from H_TOTAL-1 to 0.
  - On that wrap, vcnt increments and wraps from V_TOTAL-1 to 0.
- Counter widths are fixed at 9 bits. All totals must be ≤512 and all sync windows must lie inside their totals. No other parameter checking is done.
- hblank = (hcnt ≥ H_ACTIVE). vblank = (vcnt ≥ V_ACTIVE). de = !hblank && !vblank. These are combinational from the registered counters.
- Sync windows:
  - hs_act = hcnt in [H_SYNC_START, H_SYNC_START+H_SYNC_LEN).
  - vs_act = vcnt in [V_SYNC_START, V_SYNC_START+V_SYNC_LEN).
  - vs_act changes only at line boundaries.
- frame_start = pix_ce && hcnt==H_TOTAL-1 && vcnt==V_TOTAL-1.
- Output stage, registered on pix_ce:
  - R/G/B ← de ? *_in : 0.
  - HSYNC ← hs_act XNOR SYNC_POL.
  - VSYNC ← vs_act XNOR SYNC_POL.
  - Sync and RGB therefore stay mutually aligned.
- Reset values (rst low at a clk edge): div=0, hcnt=0, vcnt=0, R/G/B=0, HSYNC=VSYNC=inactive level (1 for SYNC_POL=0), pix_ce=0, frame_start=0. hblank, vblank and de follow the counters, so they are 0, 0 and 1.
- Reset mid-frame: all state returns to the reset values on the next edge. There is no partial line or frame. The divider phase restarts.

## Timing
- The source must present *_in for (hcnt, vcnt) before the pix_ce edge that ends that pixel period. It has CLK_DIV clks of slack.
- Output latency: R/G/B/HSYNC/VSYNC lag the counters by exactly one pixel (one pix_ce).
- After rst goes high, the first pix_ce occurs at clk CLK_DIV-1, counting the first clk with rst high as clk 0.
- Line = H_TOTAL×CLK_DIV clks. Frame = H_TOTAL×V_TOTAL×CLK_DIV clks (811008 at defaults).
- Simultaneous hcnt and vcnt wrap: both update on the same edge, and frame_start is high in that clk.

## Structure
- Package system86_video_pkg holds the default timing constants (pixel rate, H/V totals, active sizes, sync positions and lengths) and the 9-bit counter width constant. Both the bench and this block import it.
- One sub-module, system86_pix_ce_gen, contains the divider and the pix_ce decode, parameterised by CLK_DIV. The counters, sync decode and output stage live in the top module.

## Test plan
1. Reset hold: rst=0 for 10 clks with R_in=G_in=B_in=8'hFF → R/G/B=0, HSYNC=VSYNC=1, pix_ce=0, hcnt=vcnt=0 throughout.
2. Divider: release rst → pix_ce high at clks 7, 15, 23, … and exactly 1 in every 8 over 1000 clks.
3. Line timing: hblank rises when hcnt reaches 288. HSYNC pin goes low at the pix_ce after hcnt=300 and stays low for exactly 32 pixels. hcnt wraps after 383.
4. Frame timing: vcnt wraps 263→0. frame_start pulses exactly once per 811008 clks. VSYNC pin is low for 8 lines, beginning one pixel after (hcnt=0, vcnt=240).
5. Blanking gate: constant R_in=8'hA5 → R=8'hA5 for pixels 0..287 of lines 0..223, each delayed one pixel, and R=0 elsewhere. Check at pixels 287, 288 and line 224.
6. Mid-frame reset: rst=0 for 1 clk at hcnt=150, vcnt=100 → next edge gives counters 0, outputs at reset values, and the next pix_ce at clk CLK_DIV-1 after release.
